// File: rtl/trace_plot_pkg.sv
// Shared types and constants for the oscillator trace plot scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trace_plot_pkg;

    // Scheduler phases: wait for a sample, erase a column, plot trace1, plot trace2
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        PLOT1 = 2'd2,
        PLOT2 = 2'd3
    } state_t;

    // Pixel codes written alongside each coordinate
    localparam logic [1:0] DISP_ERASE = 2'b00;
    localparam logic [1:0] DISP_T1    = 2'b10;
    localparam logic [1:0] DISP_T2    = 2'b01;

    localparam int XW = 10;  // column coordinate width
    localparam int YW = 9;   // row coordinate width
    localparam int SW = 18;  // signed 2.16 solver sample width

endpackage

// File: rtl/trace_y_map.sv
// Maps one signed 2.16 solver position to a screen row inside a 128-row band.
// Latency: combinational.
// Backpressure: none.
// Ports: i_x  18b signed position; o_y  9b row = OFFSET + 127 - u, u = (x + 2^17)[17:11].
module trace_y_map
    import trace_plot_pkg::*;
#(
    parameter int OFFSET = 56
) (
    input  logic [SW-1:0] i_x,
    output logic [YW-1:0] o_y
);

    logic [6:0]  w_u;
    logic [10:0] w_unused_lsbs;

    // Adding 2^17 to an 18-bit two's-complement value only flips the sign bit,
    // giving an offset-binary code whose top 7 bits are the band position.
    assign w_u           = {~i_x[SW-1], i_x[SW-2:11]};
    assign w_unused_lsbs = i_x[10:0];

    // Screen rows grow downwards, so larger positions map to smaller rows
    assign o_y = YW'(OFFSET + 127) - {2'b00, w_u};

endmodule

// File: rtl/trace_plot_scheduler.sv
// Schedules the shared VGA pixel-write port: per accepted sample erase one column, plot trace1, plot trace2.
// Latency: first write presented 1 cycle after a plotted sample is accepted; >= SCREEN_H+2 write cycles back to IDLE.
// Backpressure: sample_ready only in IDLE; each write is held stable while w_en=1 and wr_ready=0.
// Ports: CLOCK_50, reset (async, active-high), nios_reset (sync soft restart), sample_valid/sample_ready,
//        x1/x2 (18b signed 2.16), wr_ready, w_en, write_xCoord[9:0], write_yCoord[8:0], disp_bit[1:0], col_wrap.
// Option: define TRACE_PLOT_OVERRUN_EN to add overrun_cnt[15:0] (saturating count of cycles with a refused sample).
module trace_plot_scheduler
    import trace_plot_pkg::*;
#(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int Y1_OFFSET = 56,
    parameter int Y2_OFFSET = 296,
    parameter int DECIM     = 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          nios_reset,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic [SW-1:0] x1,
    input  logic [SW-1:0] x2,
    input  logic          wr_ready,
    output logic          w_en,
    output logic [XW-1:0] write_xCoord,
    output logic [YW-1:0] write_yCoord,
    output logic [1:0]    disp_bit,
    output logic          col_wrap
`ifdef TRACE_PLOT_OVERRUN_EN
    ,
    output logic [15:0]   overrun_cnt
`endif
);

    localparam logic [XW-1:0] COL_LAST   = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] ROW_LAST   = YW'(SCREEN_H - 1);
    localparam logic [15:0]   DECIM_LAST = 16'(DECIM - 1);

    state_t        r_state, w_state_nxt;
    logic [XW-1:0] r_col,   w_col_nxt;
    logic [YW-1:0] r_row,   w_row_nxt;
    logic [15:0]   r_decim, w_decim_nxt;
    logic [YW-1:0] r_y1,    w_y1_nxt;
    logic [YW-1:0] r_y2,    w_y2_nxt;
    logic          r_wen,   w_wen_nxt;
    logic [XW-1:0] r_xc,    w_xc_nxt;
    logic [YW-1:0] r_yc,    w_yc_nxt;
    logic [1:0]    r_disp,  w_disp_nxt;
    logic          r_wrap,  w_wrap_nxt;
    logic [YW-1:0] w_y1_map, w_y2_map;
    logic          w_idle;

    trace_y_map #(.OFFSET(Y1_OFFSET)) u_y1_map (.i_x(x1), .o_y(w_y1_map));
    trace_y_map #(.OFFSET(Y2_OFFSET)) u_y2_map (.i_x(x2), .o_y(w_y2_map));

    assign w_idle       = (r_state == IDLE);
    assign sample_ready = w_idle;
    assign w_en         = r_wen;
    assign write_xCoord = r_xc;
    assign write_yCoord = r_yc;
    assign disp_bit     = r_disp;
    assign col_wrap     = r_wrap;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_decim <= '0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_wen   <= 1'b0;
            r_xc    <= '0;
            r_yc    <= '0;
            r_disp  <= DISP_ERASE;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_decim <= w_decim_nxt;
            r_y1    <= w_y1_nxt;
            r_y2    <= w_y2_nxt;
            r_wen   <= w_wen_nxt;
            r_xc    <= w_xc_nxt;
            r_yc    <= w_yc_nxt;
            r_disp  <= w_disp_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Outputs are computed one cycle ahead so the write item for the next
    // phase is already on the port the cycle after a transfer (no bubble).
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_decim_nxt = r_decim;
        w_y1_nxt    = r_y1;
        w_y2_nxt    = r_y2;
        w_wen_nxt   = r_wen;
        w_xc_nxt    = r_xc;
        w_yc_nxt    = r_yc;
        w_disp_nxt  = r_disp;
        w_wrap_nxt  = 1'b0;

        if (nios_reset) begin
            w_state_nxt = IDLE;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
            w_decim_nxt = '0;
            w_wen_nxt   = 1'b0;
            w_xc_nxt    = '0;
            w_yc_nxt    = '0;
            w_disp_nxt  = DISP_ERASE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        if (r_decim != DECIM_LAST) begin
                            w_decim_nxt = r_decim + 16'd1;
                        end else begin
                            w_decim_nxt = '0;
                            w_y1_nxt    = w_y1_map;
                            w_y2_nxt    = w_y2_map;
                            w_state_nxt = ERASE;
                            w_row_nxt   = '0;
                            w_wen_nxt   = 1'b1;
                            w_xc_nxt    = r_col;
                            w_yc_nxt    = '0;
                            w_disp_nxt  = DISP_ERASE;
                        end
                    end
                end
                // w_en is always high outside IDLE, so wr_ready alone marks a transfer
                ERASE: begin
                    if (wr_ready) begin
                        if (r_row == ROW_LAST) begin
                            w_state_nxt = PLOT1;
                            w_yc_nxt    = r_y1;
                            w_disp_nxt  = DISP_T1;
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                            w_yc_nxt  = r_row + 1'b1;
                        end
                    end
                end
                PLOT1: begin
                    if (wr_ready) begin
                        w_state_nxt = PLOT2;
                        w_yc_nxt    = r_y2;
                        w_disp_nxt  = DISP_T2;
                    end
                end
                PLOT2: begin
                    if (wr_ready) begin
                        w_state_nxt = IDLE;
                        w_wen_nxt   = 1'b0;
                        if (r_col == COL_LAST) begin
                            w_col_nxt  = '0;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_col_nxt = r_col + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_wen_nxt   = 1'b0;
                end
            endcase
        end
    end

`ifdef TRACE_PLOT_OVERRUN_EN
    logic [15:0] r_overrun;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_overrun <= '0;
        end else if (nios_reset) begin
            r_overrun <= '0;
        end else if (sample_valid && !w_idle && (r_overrun != 16'hFFFF)) begin
            r_overrun <= r_overrun + 16'd1;
        end
    end

    assign overrun_cnt = r_overrun;
`endif

endmodule

// File: tb/tb_trace_plot_scheduler.sv
module tb_trace_plot_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, nios_reset;
    // full-size instance
    logic        sv, sr, wr_ready, w_en, cw;
    logic [17:0] x1, x2;
    logic [9:0]  xc;
    logic [8:0]  yc;
    logic [1:0]  disp;
    // small-screen, decimating instance
    logic        nios2, sv2, sr2, wr2, we2, cw2;
    logic [17:0] x1b, x2b;
    logic [9:0]  xc2;
    logic [8:0]  yc2;
    logic [1:0]  disp2;
`ifdef TRACE_PLOT_OVERRUN_EN
    logic [15:0] ovr, ovr2;
`endif

    trace_plot_scheduler dut (
        .CLOCK_50(clk), .reset(reset), .nios_reset(nios_reset),
        .sample_valid(sv), .sample_ready(sr), .x1(x1), .x2(x2),
        .wr_ready(wr_ready), .w_en(w_en), .write_xCoord(xc), .write_yCoord(yc),
        .disp_bit(disp), .col_wrap(cw)
`ifdef TRACE_PLOT_OVERRUN_EN
        , .overrun_cnt(ovr)
`endif
    );

    trace_plot_scheduler #(.SCREEN_W(8), .SCREEN_H(4), .DECIM(4)) dut2 (
        .CLOCK_50(clk), .reset(reset), .nios_reset(nios2),
        .sample_valid(sv2), .sample_ready(sr2), .x1(x1b), .x2(x2b),
        .wr_ready(wr2), .w_en(we2), .write_xCoord(xc2), .write_yCoord(yc2),
        .disp_bit(disp2), .col_wrap(cw2)
`ifdef TRACE_PLOT_OVERRUN_EN
        , .overrun_cnt(ovr2)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 0;         // 0: always ready, 1: toggle, 2: random
    int m_col    = 0;         // model sweep column of the full-size instance
    int wrap1_cnt = 0, wrap2_cnt = 0, wrap2_at = -1;
    logic        prev_stall = 1'b0;
    logic [21:0] prev_out   = '0;
    logic [20:0] obs_q[$], obs2_q[$], exp_q[$], exp2_q[$];

    // Reference row mapping: offset-binary position, top 7 bits, positive up
    function automatic int ymap(input logic [17:0] x, input int off);
        int u;
        u = ((int'(x) + 131072) % 262144) / 2048;
        return off + 127 - u;
    endfunction

    // One sample's expected writes: erase every row of the column, then both traces
    function automatic void add_exp(input int sel, input int col, input int h,
                                    input logic [17:0] a, input logic [17:0] b);
        logic [20:0] e;
        for (int r = 0; r < h; r++) begin
            e = {10'(col), 9'(r), 2'b00};
            if (sel == 0) exp_q.push_back(e); else exp2_q.push_back(e);
        end
        e = {10'(col), 9'(ymap(a, 56)), 2'b10};
        if (sel == 0) exp_q.push_back(e); else exp2_q.push_back(e);
        e = {10'(col), 9'(ymap(b, 296)), 2'b01};
        if (sel == 0) exp_q.push_back(e); else exp2_q.push_back(e);
    endfunction

    function automatic int first_diff(input logic [20:0] o[$], input logic [20:0] e[$]);
        for (int i = 0; i < o.size() && i < e.size(); i++)
            if (o[i] !== e[i]) return i;
        if (o.size() != e.size()) return (o.size() < e.size()) ? o.size() : e.size();
        return -1;
    endfunction

    // Advance one cycle: drive write-port readiness, log transfers, check stalled writes hold
    task automatic step();
        logic exempt;
        @(negedge clk);
        exempt = reset || nios_reset;
        if (prev_stall && !exempt) begin
            n_checks++;
            if ({w_en, xc, yc, disp} !== prev_out)
                $display("FAIL stall_hold: got %h required %h", {w_en, xc, yc, disp}, prev_out);
            else n_pass++;
        end
        case (rdy_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ~wr_ready;
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
        wr2 = 1'($urandom_range(0, 1));
        prev_stall = w_en && !wr_ready;
        prev_out   = {w_en, xc, yc, disp};
        if (w_en && wr_ready) obs_q.push_back({xc, yc, disp});
        if (we2 && wr2) obs2_q.push_back({xc2, yc2, disp2});
        if (cw) wrap1_cnt++;
        if (cw2) begin wrap2_cnt++; wrap2_at = obs2_q.size(); end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            step();
            if (sr) ok = 1'b1;
        end
    endtask

    task automatic wait_idle2(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (sr2) ok = 1'b1;
        end
    endtask

    // Present one sample to the full-size instance (assumed idle) and run it to completion
    task automatic send(input logic [17:0] a, input logic [17:0] b, input bit chk_lat, output bit ok);
        sv = 1'b1; x1 = a; x2 = b;
        step();
        sv = 1'b0;
        if (chk_lat) begin
            n_checks++;
            if ({w_en, xc, yc, disp} !== {1'b1, 10'(m_col), 9'd0, 2'b00})
                $display("FAIL first_write: got %h required %h", {w_en, xc, yc, disp}, {1'b1, 10'(m_col), 9'd0, 2'b00});
            else n_pass++;
        end
        add_exp(0, m_col, 480, a, b);
        m_col = (m_col + 1) % 640;
        wait_idle(ok);
    endtask

    task automatic check_writes(input string nm);
        int d;
        d = first_diff(obs_q, exp_q);
        n_checks++;
        if (d != -1)
            $display("FAIL %s: write %0d got %h required %h (got %0d writes, required %0d)", nm, d,
                     (d < obs_q.size()) ? obs_q[d] : 21'h0, (d < exp_q.size()) ? exp_q[d] : 21'h0,
                     obs_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; nios_reset = 1'b0; nios2 = 1'b0;
        sv = 1'b0; sv2 = 1'b0; x1 = '0; x2 = '0; x1b = '0; x2b = '0;
        wr_ready = 1'b1; wr2 = 1'b1;
        step(); step();
        n_checks++;
        if ({w_en, xc, yc, disp, cw, sr} !== {1'b0, 10'd0, 9'd0, 2'b00, 1'b0, 1'b1})
            $display("FAIL reset_outputs: got %h required %h", {w_en, xc, yc, disp, cw, sr}, {1'b0, 10'd0, 9'd0, 2'b00, 1'b0, 1'b1});
        else n_pass++;
        n_checks++;
        if ({we2, sr2} !== 2'b01) $display("FAIL reset_outputs2: got %b required 01", {we2, sr2});
        else n_pass++;
`ifdef TRACE_PLOT_OVERRUN_EN
        n_checks++;
        if (ovr !== 16'd0) $display("FAIL reset_overrun: got %0d required 0", ovr);
        else n_pass++;
`endif
        reset = 1'b0;
        step();
        obs_q.delete(); obs2_q.delete();
    endtask

    task automatic test_basic();
        bit ok;
        rdy_mode = 0; obs_q.delete(); exp_q.delete();
        send(18'h0, 18'h0, 1'b1, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_timeout: idle not reached"); else n_pass++;
        n_checks++;
        if (obs_q.size() != 482) $display("FAIL basic_count: got %0d required 482", obs_q.size()); else n_pass++;
        check_writes("basic_writes");
    endtask

    task automatic test_extremes();
        bit ok;
        rdy_mode = 2; obs_q.delete(); exp_q.delete();
        send(18'h1FFFF, 18'h20000, 1'b1, ok);
        n_checks++;
        if (!ok || obs_q.size() != 482) $display("FAIL extremes_count: got %0d required 482", obs_q.size());
        else n_pass++;
        n_checks++;
        if (obs_q.size() == 482 && (obs_q[480][10:2] !== 9'd56 || obs_q[481][10:2] !== 9'd423))
            $display("FAIL extremes_rows: got %0d,%0d required 56,423", obs_q[480][10:2], obs_q[481][10:2]);
        else if (obs_q.size() == 482) n_pass++;
        else $display("FAIL extremes_rows: got %0d writes required 482", obs_q.size());
        check_writes("extremes_writes");
    endtask

    task automatic test_stall();
        bit ok;
        rdy_mode = 1; obs_q.delete(); exp_q.delete();
        send(18'($urandom), 18'($urandom), 1'b1, ok);
        n_checks++;
        if (!ok || obs_q.size() != 482) $display("FAIL stall_count: got %0d required 482", obs_q.size());
        else n_pass++;
        check_writes("stall_writes");
    endtask

    task automatic test_overrun();
        bit ok;
        logic [17:0] a, b;
        rdy_mode = 2;
        nios_reset = 1'b1; step(); nios_reset = 1'b0; step();
        m_col = 0; obs_q.delete(); exp_q.delete();
        a = 18'($urandom); b = 18'($urandom);
        sv = 1'b1; x1 = a; x2 = b;
        step();
        add_exp(0, m_col, 480, a, b);
        m_col = m_col + 1;
        for (int i = 0; i < 20; i++) begin
            x1 = 18'($urandom); x2 = 18'($urandom);
            step();
            n_checks++;
            if (sr !== 1'b0) $display("FAIL busy_ready: cycle %0d got %b required 0", i, sr);
            else n_pass++;
        end
        sv = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL overrun_timeout: idle not reached"); else n_pass++;
        check_writes("overrun_writes");
`ifdef TRACE_PLOT_OVERRUN_EN
        n_checks++;
        if (ovr !== 16'd20) $display("FAIL overrun_cnt: got %0d required 20", ovr);
        else n_pass++;
`endif
    endtask

    task automatic test_nios_reset();
        bit ok;
        rdy_mode = 0;
        sv = 1'b1; x1 = 18'($urandom); x2 = 18'($urandom);
        step();
        sv = 1'b0;
        for (int i = 0; i < 10; i++) step();
        nios_reset = 1'b1;
        step();
        nios_reset = 1'b0;
        n_checks++;
        if ({w_en, sr} !== 2'b01) $display("FAIL nios_abort: got w_en,ready=%b required 01", {w_en, sr});
        else n_pass++;
        m_col = 0; obs_q.delete(); exp_q.delete();
        send(18'($urandom), 18'($urandom), 1'b1, ok);
        check_writes("nios_restart_writes");
    endtask

    task automatic test_back_to_back();
        bit ok;
        rdy_mode = 2; obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) send(18'($urandom), 18'($urandom), 1'b0, ok);
        n_checks++;
        if (wrap1_cnt != 0) $display("FAIL no_early_wrap: got %0d required 0", wrap1_cnt);
        else n_pass++;
        check_writes("b2b_writes");
    endtask

    task automatic test_decim_wrap();
        bit ok;
        int pc, d;
        logic [17:0] a, b;
        pc = 0; obs2_q.delete(); exp2_q.delete();
        for (int k = 0; k < 40; k++) begin
            a = 18'($urandom); b = 18'($urandom);
            sv2 = 1'b1; x1b = a; x2b = b;
            step();
            sv2 = 1'b0;
            if (k % 4 == 3) begin add_exp(1, pc % 8, 4, a, b); pc++; end
            wait_idle2(ok);
            if (k == 7) begin
                n_checks++;
                if (obs2_q.size() != 12) $display("FAIL decim_count: got %0d writes required 12", obs2_q.size());
                else n_pass++;
            end
        end
        n_checks++;
        if (wrap2_cnt != 1 || wrap2_at != 48)
            $display("FAIL wrap_pulse: got %0d pulses after %0d writes required 1 after 48", wrap2_cnt, wrap2_at);
        else n_pass++;
        d = first_diff(obs2_q, exp2_q);
        n_checks++;
        if (d != -1) $display("FAIL decim_writes: write %0d differs (got %0d writes required %0d)", d, obs2_q.size(), exp2_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_stall();
        test_overrun();
        test_nios_reset();
        test_back_to_back();
        test_decim_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
